// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// instr_fetch_pkg: shared types and constants for the instruction fetch unit.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR_WORD = 32'h0000_0013;

  localparam logic [1:0] HALT_NONE     = 2'd0;
  localparam logic [1:0] HALT_ILL      = 2'd1;
  localparam logic [1:0] HALT_MISALIGN = 2'd2;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage : instr_fetch_pkg
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// instr_fetch: PC owner, req/ack instruction memory reader and valid/ready
// presenter of the held instruction; halts on illegal or misaligned redirects.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_WORD
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        ill_instr,
  output logic        halted,
  output logic [1:0]  halt_cause,
  output logic [31:0] instret
);

  fetch_state_t state;

  logic        misaligned;
  logic [31:0] next_pc;

  assign misaligned = branch_taken && (branch_target[1:0] != 2'b00);
  assign next_pc    = branch_taken ? branch_target : pc + PC_STEP;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      halt_cause  <= HALT_NONE;
      instret     <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          state     <= ST_FETCH;
          imem_req  <= 1'b1;
          imem_addr <= pc;
        end

        ST_FETCH: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= ST_HOLD;
          end
        end

        ST_HOLD: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            instr       <= NOP_INSTR;
            if (ill_instr) begin
              state      <= ST_HALT;
              halted     <= 1'b1;
              halt_cause <= HALT_ILL;
            end else if (misaligned) begin
              // pc records the faulting target; imem_addr keeps its aligned value
              state      <= ST_HALT;
              halted     <= 1'b1;
              halt_cause <= HALT_MISALIGN;
              pc         <= branch_target;
              instret    <= instret + 32'd1;
            end else begin
              state     <= ST_FETCH;
              pc        <= next_pc;
              imem_addr <= next_pc;
              imem_req  <= 1'b1;
              instret   <= instret + 32'd1;
            end
          end
        end

        ST_HALT: begin
          state <= ST_HALT;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : instr_fetch
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// tb_instr_fetch: table-driven directed checks of fetch, redirect, halt and reset.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] pc;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        ill_instr = 1'b0;
  logic        halted;
  logic [1:0]  halt_cause;
  logic [31:0] instret;

  logic ack_on = 1'b1;
  logic ack_force = 1'b0;
  int   ack_delay = 0;
  int   wait_cnt;
  int   total = 0;
  int   bad = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  instr_fetch #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready), .pc(pc),
    .branch_taken(branch_taken), .branch_target(branch_target), .ill_instr(ill_instr),
    .halted(halted), .halt_cause(halt_cause), .instret(instret)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0)      return 32'h0050_0093;
    else if (a == 32'h4) return 32'h0010_0113;
    else                 return a ^ 32'h5A5A_0013;
  endfunction

  // Memory model: acks once the request has been waiting ack_delay cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) wait_cnt <= 0;
    else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end
  assign imem_ack   = ack_force | (ack_on & imem_req & (wait_cnt >= ack_delay));
  assign imem_rdata = mem_word(imem_addr);

  typedef struct {
    logic        bt;
    logic [31:0] tgt;
    logic        ill;
    logic [31:0] exp_pc;
    logic [31:0] exp_pc_next;
    logic [31:0] exp_instret;
    logic        exp_halted;
    logic [1:0]  exp_cause;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, output int waited);
    waited = 0;
    while (!instr_valid && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("valid_timeout", {31'd0, instr_valid}, 32'd1);
    chk("hold_pc", pc, v.exp_pc);
    chk("hold_instr", instr, mem_word(v.exp_pc));
    chk("hold_req", {31'd0, imem_req}, 32'd0);
    instr_ready = 1'b1; branch_taken = v.bt; branch_target = v.tgt; ill_instr = v.ill;
    @(posedge clk); #1;
    instr_ready = 1'b0; branch_taken = 1'b0; ill_instr = 1'b0;
    chk("post_valid", {31'd0, instr_valid}, 32'd0);
    chk("post_pc", pc, v.exp_pc_next);
    chk("post_instret", instret, v.exp_instret);
    chk("post_halted", {31'd0, halted}, {31'd0, v.exp_halted});
    chk("post_cause", {30'd0, halt_cause}, {30'd0, v.exp_cause});
    chk("post_instr_nop", instr, NOP);
    if (!v.exp_halted) begin
      chk("next_req", {31'd0, imem_req}, 32'd1);
      chk("next_addr", imem_addr, v.exp_pc_next);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    instr_ready = 1'b0; branch_taken = 1'b0; ill_instr = 1'b0; ack_force = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr", instr, NOP);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_cause", {30'd0, halt_cause}, 32'd0);
    chk("rst_instret", instret, 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_req", {31'd0, imem_req}, 32'd0);
  endtask

  initial begin
    int w;
    vec_t ill_v;
    vecs[0] = '{1'b0, 32'h0,  1'b0, 32'h00, 32'h04, 32'd1, 1'b0, 2'd0};
    vecs[1] = '{1'b0, 32'h0,  1'b0, 32'h04, 32'h08, 32'd2, 1'b0, 2'd0};
    vecs[2] = '{1'b0, 32'h0,  1'b0, 32'h08, 32'h0C, 32'd3, 1'b0, 2'd0};
    vecs[3] = '{1'b0, 32'h0,  1'b0, 32'h0C, 32'h10, 32'd4, 1'b0, 2'd0};
    vecs[4] = '{1'b1, 32'h40, 1'b0, 32'h10, 32'h40, 32'd5, 1'b0, 2'd0};
    vecs[5] = '{1'b0, 32'h0,  1'b0, 32'h40, 32'h44, 32'd6, 1'b0, 2'd0};
    vecs[6] = '{1'b1, 32'h42, 1'b0, 32'h44, 32'h42, 32'd7, 1'b1, 2'd2};
    ill_v   = '{1'b0, 32'h0,  1'b1, 32'h08, 32'h08, 32'd2, 1'b1, 2'd1};

    // Main table: immediate acks, sequential, branch, then misaligned branch.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      apply(vecs[i], w);
      if (i > 0) chk("latency_wait", w, 32'd1);
      else       chk("first_latency", w, 32'd2);
    end

    // Halt ignores acks, ready and branches.
    ack_force = 1'b1; instr_ready = 1'b1; branch_taken = 1'b1; branch_target = 32'h100;
    repeat (3) @(posedge clk);
    #1;
    ack_force = 1'b0; instr_ready = 1'b0; branch_taken = 1'b0;
    chk("halt_hold_halted", {31'd0, halted}, 32'd1);
    chk("halt_hold_pc", pc, 32'h42);
    chk("halt_hold_instret", instret, 32'd7);
    chk("halt_hold_req", {31'd0, imem_req}, 32'd0);
    chk("halt_hold_valid", {31'd0, instr_valid}, 32'd0);
    chk("halt_addr_aligned", {30'd0, imem_addr[1:0]}, 32'd0);

    // Illegal instruction at pc=8.
    do_reset();
    apply(vecs[0], w);
    apply(vecs[1], w);
    apply(ill_v, w);
    ack_force = 1'b1; instr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    ack_force = 1'b0; instr_ready = 1'b0;
    chk("ill_stay_cause", {30'd0, halt_cause}, 32'd1);
    chk("ill_stay_pc", pc, 32'h08);
    chk("ill_stay_instret", instret, 32'd2);
    chk("ill_stay_valid", {31'd0, instr_valid}, 32'd0);

    // Memory ack delayed 3 cycles.
    ack_delay = 3;
    do_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      chk("dly_req", {31'd0, imem_req}, 32'd1);
      chk("dly_addr", imem_addr, 32'h0);
      chk("dly_valid", {31'd0, instr_valid}, 32'd0);
      @(posedge clk); #1;
    end
    chk("dly_valid_pre_ack", {31'd0, instr_valid}, 32'd0);
    @(posedge clk); #1;
    chk("dly_valid_after_ack", {31'd0, instr_valid}, 32'd1);
    ack_delay = 0;
    apply(vecs[0], w);

    // Reset mid-fetch at addr 4 with a response arriving during/after reset.
    ack_on = 1'b0;
    #1;
    chk("mid_req", {31'd0, imem_req}, 32'd1);
    chk("mid_addr", imem_addr, 32'h4);
    rst = 1'b1;
    #1;
    chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
    chk("mid_rst_addr", imem_addr, 32'h0);
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_instret", instret, 32'd0);
    @(negedge clk);
    rst = 1'b0; ack_force = 1'b1;
    @(posedge clk); #1;
    ack_force = 1'b0;
    chk("late_ack_valid", {31'd0, instr_valid}, 32'd0);
    chk("late_ack_req", {31'd0, imem_req}, 32'd1);
    chk("late_ack_addr", imem_addr, 32'h0);
    chk("late_ack_instr", instr, NOP);
    ack_on = 1'b1;
    apply(vecs[0], w);
    chk("restart_latency", w, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_instr_fetch
`default_nettype wire
